// File: rtl/vga_timing_gen_if.sv
// Pixel-timing bundle (counts, syncs, blanks, start-of-frame) passed from the
// timing generator to the draw_* pipeline stages. No RGB data travels here.
interface vga_timing_gen_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic        sof;

    // Timing source drives the bundle.
    modport master (
        output hcount, vcount, hsync, vsync, hblnk, vblnk, sof
    );

    // Draw stages consume the bundle.
    modport slave (
        input hcount, vcount, hsync, vsync, hblnk, vblnk, sof
    );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing generator (default 800x600@60 Hz, 40 MHz pixel clock).
// Produces registered hcount/vcount, hsync/vsync, hblnk/vblnk and a one-cycle
// start-of-frame strobe. Every output is decoded from the *next* counter
// values, so all of them change on the same edge with no relative skew.
// Optional: define VGA_TIMING_FRAME_CNT_EN to add a 16-bit wrapping frame
// counter output (frame_cnt) that steps on each start-of-frame.
module vga_timing_gen #(
    parameter int   H_ACTIVE  = 800,
    parameter int   H_FP      = 40,
    parameter int   H_SYNC    = 128,
    parameter int   H_BP      = 88,
    parameter int   V_ACTIVE  = 600,
    parameter int   V_FP      = 1,
    parameter int   V_SYNC    = 4,
    parameter int   V_BP      = 23,
    parameter logic HSYNC_POL = 1'b1,
    parameter logic VSYNC_POL = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    vga_timing_gen_if.master  vga
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]       frame_cnt
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counters are 11 bits wide; larger modes cannot be represented.
    if ((H_TOTAL > 2047) || (V_TOTAL > 2047)) begin : g_size_check
        $error("vga_timing_gen: H_TOTAL/V_TOTAL must not exceed 2047");
    end

    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_ACT      = 11'(H_ACTIVE);
    localparam logic [10:0] V_ACT      = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START   = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] HS_END     = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);

    logic [10:0] hcount_r;
    logic [10:0] vcount_r;
    logic        hsync_r;
    logic        vsync_r;
    logic        hblnk_r;
    logic        vblnk_r;
    logic        sof_r;

    logic [10:0] h_next_s;
    logic [10:0] v_next_s;
    logic        frame_wrap_s;
    logic        hsync_next_s;
    logic        vsync_next_s;
    logic        hblnk_next_s;
    logic        vblnk_next_s;

    // Next counter values: advance on en, wrap line then frame; hold otherwise.
    always_comb begin
        h_next_s     = hcount_r;
        v_next_s     = vcount_r;
        frame_wrap_s = 1'b0;
        if (en) begin
            if (hcount_r == H_LAST) begin
                h_next_s = 11'd0;
                if (vcount_r == V_LAST) begin
                    v_next_s     = 11'd0;
                    frame_wrap_s = 1'b1;
                end else begin
                    v_next_s = vcount_r + 11'd1;
                end
            end else begin
                h_next_s = hcount_r + 11'd1;
            end
        end else begin
            h_next_s = hcount_r;
            v_next_s = vcount_r;
        end
    end

    // Sync/blank decode on the next counts so outputs line up with the counts.
    always_comb begin
        hsync_next_s = ((h_next_s >= HS_START) && (h_next_s < HS_END)) ? HSYNC_POL : ~HSYNC_POL;
        vsync_next_s = ((v_next_s >= VS_START) && (v_next_s < VS_END)) ? VSYNC_POL : ~VSYNC_POL;
        hblnk_next_s = (h_next_s >= H_ACT);
        vblnk_next_s = (v_next_s >= V_ACT);
    end

    // Output registers; reset restarts at (0,0) with syncs inactive.
    always_ff @(posedge clk) begin
        if (rst) begin
            hcount_r <= 11'd0;
            vcount_r <= 11'd0;
            hsync_r  <= ~HSYNC_POL;
            vsync_r  <= ~VSYNC_POL;
            hblnk_r  <= 1'b0;
            vblnk_r  <= 1'b0;
            sof_r    <= 1'b0;
        end else begin
            hcount_r <= h_next_s;
            vcount_r <= v_next_s;
            hsync_r  <= hsync_next_s;
            vsync_r  <= vsync_next_s;
            hblnk_r  <= hblnk_next_s;
            vblnk_r  <= vblnk_next_s;
            sof_r    <= frame_wrap_s;
        end
    end

    assign vga.hcount = hcount_r;
    assign vga.vcount = vcount_r;
    assign vga.hsync  = hsync_r;
    assign vga.vsync  = vsync_r;
    assign vga.hblnk  = hblnk_r;
    assign vga.vblnk  = vblnk_r;
    assign vga.sof    = sof_r;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_r;

    // Frame counter steps together with the start-of-frame strobe; wraps at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt_r <= 16'd0;
        end else if (frame_wrap_s) begin
            frame_cnt_r <= frame_cnt_r + 16'd1;
        end else begin
            frame_cnt_r <= frame_cnt_r;
        end
    end

    assign frame_cnt = frame_cnt_r;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Testbench for vga_timing_gen. Two instances share clk/rst/en: u0 at the
// default 800x600 mode, u1 at a tiny mode with active-low syncs so whole
// frames fit in a short run. A position model (count of enabled advances since
// reset) predicts every output of both instances on every cycle.
module tb_vga_timing_gen;

    typedef struct packed {
        logic [10:0] h;
        logic [10:0] v;
        logic        hs;
        logic        vs;
        logic        hb;
        logic        vb;
        logic        sof;
    } obs_t;

    typedef struct {
        bit rst;
        bit en;
        int n;
        int h;
        int v;
        bit hs;
        bit hb;
    } vec_t;

    // Small mode for u1: H_TOTAL=31, V_TOTAL=19, frame=589 cycles.
    localparam int S_HA = 16, S_HF = 4, S_HS = 6, S_HB = 5;
    localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 4;
    localparam int S_FRAME = 589;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en  = 1'b0;

    int checks   = 0;
    int failures = 0;

    int p   = 0;     // enabled advances since last reset
    bit adv = 1'b0;  // last edge advanced
    int fc1 = 0;     // expected frame counter of u1

    vga_timing_gen_if if0 ();
    vga_timing_gen_if if1 ();

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc0_out;
    logic [15:0] fc1_out;
`endif

    vga_timing_gen u0 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vga (if0)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt (fc0_out)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
        .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
        .HSYNC_POL (1'b0), .VSYNC_POL (1'b0)
    ) u1 (
        .clk (clk),
        .rst (rst),
        .en  (en),
        .vga (if1)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_cnt (fc1_out)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected outputs for a mode, derived from the position in the frame.
    function automatic obs_t model(input int pp, input bit a,
                                   input int ha, input int hf, input int hs, input int hb,
                                   input int va, input int vf, input int vs, input int vb,
                                   input bit hpol, input bit vpol);
        obs_t m;
        int ht, vt, h, v;
        ht    = ha + hf + hs + hb;
        vt    = va + vf + vs + vb;
        h     = pp % ht;
        v     = (pp / ht) % vt;
        m.h   = 11'(h);
        m.v   = 11'(v);
        m.hs  = ((h >= ha + hf) && (h < ha + hf + hs)) ? hpol : !hpol;
        m.vs  = ((v >= va + vf) && (v < va + vf + vs)) ? vpol : !vpol;
        m.hb  = (h >= ha);
        m.vb  = (v >= va);
        m.sof = a && (pp != 0) && ((pp % (ht * vt)) == 0);
        return m;
    endfunction

    task automatic cmp_obs(input string tag, input obs_t a, input obs_t e);
        chk({tag, ".hcount"}, 32'(a.h), 32'(e.h));
        chk({tag, ".vcount"}, 32'(a.v), 32'(e.v));
        chk({tag, ".hsync"},  32'(a.hs), 32'(e.hs));
        chk({tag, ".vsync"},  32'(a.vs), 32'(e.vs));
        chk({tag, ".hblnk"},  32'(a.hb), 32'(e.hb));
        chk({tag, ".vblnk"},  32'(a.vb), 32'(e.vb));
        chk({tag, ".sof"},    32'(a.sof), 32'(e.sof));
    endtask

    task automatic check_all();
        obs_t a0, a1;
        a0 = '{if0.hcount, if0.vcount, if0.hsync, if0.vsync, if0.hblnk, if0.vblnk, if0.sof};
        a1 = '{if1.hcount, if1.vcount, if1.hsync, if1.vsync, if1.hblnk, if1.vblnk, if1.sof};
        cmp_obs("u0", a0, model(p, adv, 800, 40, 128, 88, 600, 1, 4, 23, 1'b1, 1'b1));
        cmp_obs("u1", a1, model(p, adv, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1'b0, 1'b0));
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("u0.frame_cnt", 32'(fc0_out), 32'd0);
        chk("u1.frame_cnt", 32'(fc1_out), 32'(fc1));
`endif
    endtask

    // One clock: advance the model with the inputs seen at the edge, then check.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            p = 0; adv = 1'b0; fc1 = 0;
        end else if (en) begin
            p++; adv = 1'b1;
            if ((p % S_FRAME) == 0) fc1 = (fc1 + 1) % 65536;
        end else begin
            adv = 1'b0;
        end
        @(negedge clk);
        check_all();
    endtask

    initial begin
        vec_t tbl[10];
        int   hs_cnt, hb_cnt, vs_cnt, vb_cnt, sof_cnt;
        int   sof_at[3];

        tbl[0] = '{1'b1, 1'b1,   2,    0, 0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b1, 500,  500, 0, 1'b0, 1'b0};
        tbl[2] = '{1'b0, 1'b0,  10,  500, 0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1,   1,  501, 0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 299,  800, 0, 1'b0, 1'b1};
        tbl[5] = '{1'b0, 1'b1,  40,  840, 0, 1'b1, 1'b1};
        tbl[6] = '{1'b0, 1'b1, 127,  967, 0, 1'b1, 1'b1};
        tbl[7] = '{1'b0, 1'b1,   1,  968, 0, 1'b0, 1'b1};
        tbl[8] = '{1'b0, 1'b1,  87, 1055, 0, 1'b0, 1'b1};
        tbl[9] = '{1'b0, 1'b1,   1,    0, 1, 1'b0, 1'b0};

        // Table: first line of the default mode, including a 10-cycle freeze.
        for (int i = 0; i < 10; i++) begin
            rst = tbl[i].rst;
            en  = tbl[i].en;
            for (int k = 0; k < tbl[i].n; k++) tick();
            chk($sformatf("tbl%0d.hcount", i), 32'(if0.hcount), 32'(tbl[i].h));
            chk($sformatf("tbl%0d.vcount", i), 32'(if0.vcount), 32'(tbl[i].v));
            chk($sformatf("tbl%0d.hsync", i),  32'(if0.hsync),  32'(tbl[i].hs));
            chk($sformatf("tbl%0d.hblnk", i),  32'(if0.hblnk),  32'(tbl[i].hb));
            chk($sformatf("tbl%0d.sof", i),    32'(if0.sof),    32'd0);
        end

        // One full default line: hsync window width and blanking width.
        hs_cnt = 0; hb_cnt = 0;
        for (int k = 0; k < 1056; k++) begin
            tick();
            if (if0.hsync === 1'b1) hs_cnt++;
            if (if0.hblnk === 1'b1) hb_cnt++;
        end
        chk("line.hsync_cycles", 32'(hs_cnt), 32'd128);
        chk("line.hblnk_cycles", 32'(hb_cnt), 32'd256);

        // Three small-mode frames from reset: sof timing, vsync/vblank widths.
        rst = 1'b1; tick(); rst = 1'b0; en = 1'b1;
        vs_cnt = 0; vb_cnt = 0; sof_cnt = 0;
        sof_at[0] = 0; sof_at[1] = 0; sof_at[2] = 0;
        for (int k = 1; k <= 3 * S_FRAME; k++) begin
            tick();
            if ((k <= S_FRAME) && (if1.vsync === 1'b0)) vs_cnt++;
            if ((k <= S_FRAME) && (if1.vblnk === 1'b1)) vb_cnt++;
            if (if1.sof === 1'b1) begin
                if (sof_cnt < 3) begin
                    sof_at[sof_cnt] = k;
`ifdef VGA_TIMING_FRAME_CNT_EN
                    chk($sformatf("frame_cnt.at_sof%0d", sof_cnt), 32'(fc1_out), 32'(sof_cnt + 1));
`endif
                end
                sof_cnt++;
            end
        end
        chk("frame.vsync_cycles", 32'(vs_cnt), 32'd93);
        chk("frame.vblnk_cycles", 32'(vb_cnt), 32'd279);
        chk("frame.sof_count", 32'(sof_cnt), 32'd3);
        chk("frame.sof0_cycle", 32'(sof_at[0]), 32'd589);
        chk("frame.sof1_cycle", 32'(sof_at[1]), 32'd1178);
        chk("frame.sof2_cycle", 32'(sof_at[2]), 32'd1767);

        // Random enable with rare resets, checked against the model every cycle.
        for (int k = 0; k < 3000; k++) begin
            en  = ($urandom_range(0, 3) != 0);
            rst = ($urandom_range(0, 499) == 0);
            tick();
        end

        // Reset mid-frame while both syncs of u1 are active.
        rst = 1'b1; en = 1'b1; tick(); rst = 1'b0;
        for (int k = 0; k < 425; k++) tick();
        chk("midrst.pre_h", 32'(if1.hcount), 32'd22);
        chk("midrst.pre_v", 32'(if1.vcount), 32'd13);
        chk("midrst.pre_hsync", 32'(if1.hsync), 32'd0);
        chk("midrst.pre_vsync", 32'(if1.vsync), 32'd0);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("midrst.h", 32'(if1.hcount), 32'd0);
        chk("midrst.v", 32'(if1.vcount), 32'd0);
        chk("midrst.hsync", 32'(if1.hsync), 32'd1);
        chk("midrst.vsync", 32'(if1.vsync), 32'd1);
        chk("midrst.hblnk", 32'(if1.hblnk), 32'd0);
        chk("midrst.vblnk", 32'(if1.vblnk), 32'd0);
        chk("midrst.sof", 32'(if1.sof), 32'd0);
        chk("midrst.u0_hsync", 32'(if0.hsync), 32'd0);

`ifdef VGA_TIMING_FRAME_CNT_EN
        // Preload the frame counter to its maximum; the next sof must wrap it.
        for (int k = 0; k < S_FRAME - 1; k++) tick();
        force u1.frame_cnt_r = 16'hFFFF;
        #1;
        release u1.frame_cnt_r;
        fc1 = 65535;
        tick();
        chk("frame_cnt.wrap_sof", 32'(if1.sof), 32'd1);
        chk("frame_cnt.wrap_val", 32'(fc1_out), 32'd0);
`endif

        en = 1'b0;
        tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
